ssd1306_spi_sink: RTL and testbench

Receive-side model of the SSD1306 4-wire SPI panel interface: it deserialises the controller's chip-select, data/command, serial clock and data lines into bytes. It decodes the command stream (display on/off, addressing mode, column/page windows, page-mode pointers) and turns data bytes into addressed GDDRAM write strobes. It sits in the LCD testbench and on-chip loopback builds, on the far side of the `lcd` driver's `o_rst/o_cs/o_dc/o_clk/o_data` pins, so driver output is checked as decoded pixels instead of waveforms.

---
 rtl/ssd1306_spi_sink.sv | 231 +++++++++++++++++++++++
 tb/tb_ssd1306_spi_sink.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_spi_sink.sv
// ssd1306_spi_sink: receive side of the SSD1306 4-wire SPI panel link.
// Deserialises CS/DC/SCLK/MOSI into bytes, runs the command parser and
// turns data bytes into addressed GDDRAM write strobes.
module ssd1306_spi_sink #(
  parameter int SYNC_STAGES = 2   // >= 2; depth of the input synchronisers
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_spi_rst,
  input  logic       i_spi_cs,
  input  logic       i_spi_dc,
  input  logic       i_spi_clk,
  input  logic       i_spi_data,
  output logic [7:0] o_byte,
  output logic       o_byte_dc,
  output logic       o_byte_valid,
  output logic       o_disp_on,
  output logic       o_wr_en,
  output logic [6:0] o_wr_col,
  output logic [2:0] o_wr_page,
  output logic [7:0] o_wr_data,
  output logic       o_frame_done
);

  localparam int         LAST   = SYNC_STAGES - 1;
  localparam logic [1:0] MODE_H = 2'b00;
  localparam logic [1:0] MODE_P = 2'b10;

  typedef enum logic [2:0] {
    CMD, ARG1, COL_S, COL_E, PAGE_S, PAGE_E
  } state_t;

  // One GDDRAM write as presented on the o_wr_* pins.
  typedef struct packed {
    logic       en;
    logic [6:0] col;
    logic [2:0] page;
    logic [7:0] data;
    logic       frame;
  } wr_t;

  // Synchroniser lanes: {data, sclk, dc, cs}; stage 0 faces the pins.
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic cs_s, dc_s, sclk_s, dat_s;
  logic rst_all;

  // Bit assembly
  logic       sclk_d;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q;
  logic       sclk_rise;
  logic       byte_done;
  logic [7:0] byte_nxt;

  // Parser and addressing
  state_t     state_q, state_d;
  logic       arg_is_mode;
  logic [1:0] mode_q;
  logic [6:0] col_q, col_start_q, col_end_q;
  logic [2:0] page_q, page_start_q, page_end_q;
  logic       horiz;
  wr_t        wr_q;

  // Panel reset clears everything except the synchronisers.
  assign rst_all = i_rst | ~i_spi_rst;
  assign {dat_s, sclk_s, dc_s, cs_s} = sync_q[LAST];

  assign sclk_rise = sclk_s & ~sclk_d;
  // CS high wins over a coincident SCLK rise: the bit is never taken.
  assign byte_done = sclk_rise & ~cs_s & (bit_cnt == 3'd7);
  assign byte_nxt  = {shift_q[6:0], dat_s};
  assign horiz     = (mode_q == MODE_H);

  // Synchronise all SPI pins into the i_clk domain; CS idles deasserted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b0001;
    end else begin
      sync_q[0] <= {i_spi_data, i_spi_clk, i_spi_dc, i_spi_cs};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Detect SCLK rises and shift MOSI into bytes, MSB first.
  always_ff @(posedge i_clk) begin
    if (rst_all) begin
      sclk_d       <= 1'b0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      o_byte       <= '0;
      o_byte_dc    <= 1'b0;
      o_byte_valid <= 1'b0;
    end else begin
      sclk_d       <= sclk_s;
      o_byte_valid <= byte_done;
      if (cs_s) begin
        // Partial byte is dropped; shift register keeps its contents.
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift_q <= byte_nxt;
        bit_cnt <= bit_cnt + 3'd1;   // 7 -> 0 allows back-to-back bytes
      end
      if (byte_done) begin
        o_byte    <= byte_nxt;
        o_byte_dc <= dc_s;
      end
    end
  end

  // Parser state register.
  always_ff @(posedge i_clk) begin
    if (rst_all) state_q <= CMD;
    else         state_q <= state_d;
  end

  // Parser next state: command bytes walk the argument states, data bytes
  // always drop back to CMD.
  always_comb begin
    state_d = state_q;
    if (byte_done) begin
      if (dc_s) begin
        state_d = CMD;
      end else begin
        case (state_q)
          CMD: begin
            case (byte_nxt)
              8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
              8'hD5, 8'hD9, 8'hDA, 8'hDB:     state_d = ARG1;
              8'h21:                          state_d = COL_S;
              8'h22:                          state_d = PAGE_S;
              default:                        state_d = CMD;
            endcase
          end
          ARG1:    state_d = CMD;
          COL_S:   state_d = COL_E;
          COL_E:   state_d = CMD;
          PAGE_S:  state_d = PAGE_E;
          PAGE_E:  state_d = CMD;
          default: state_d = CMD;
        endcase
      end
    end
  end

  // Command side effects, write strobes and pointer advance. The write is
  // issued with the current pointers; they advance on the edge after, while
  // the strobe is visible.
  always_ff @(posedge i_clk) begin
    if (rst_all) begin
      o_disp_on    <= 1'b0;
      arg_is_mode  <= 1'b0;
      mode_q       <= MODE_P;
      col_start_q  <= 7'd0;
      col_end_q    <= 7'd127;
      page_start_q <= 3'd0;
      page_end_q   <= 3'd7;
      col_q        <= 7'd0;
      page_q       <= 3'd0;
      wr_q         <= '0;
    end else begin
      wr_q.en    <= 1'b0;
      wr_q.frame <= 1'b0;

      if (wr_q.en) begin
        if (horiz) begin
          if (col_q != col_end_q) begin
            col_q <= col_q + 7'd1;
          end else begin
            col_q <= col_start_q;
            if (page_q == page_end_q) page_q <= page_start_q;
            else                      page_q <= page_q + 3'd1;
          end
        end else begin
          col_q <= col_q + 7'd1;        // 127 wraps to 0, page untouched
        end
      end

      if (byte_done) begin
        if (dc_s) begin
          wr_q.en    <= 1'b1;
          wr_q.col   <= col_q;
          wr_q.page  <= page_q;
          wr_q.data  <= byte_nxt;
          wr_q.frame <= horiz && (col_q == col_end_q) && (page_q == page_end_q);
        end else begin
          case (state_q)
            CMD: begin
              arg_is_mode <= (byte_nxt == 8'h20);
              if (byte_nxt == 8'hAE) o_disp_on <= 1'b0;
              if (byte_nxt == 8'hAF) o_disp_on <= 1'b1;
              // Direct pointer commands only mean something in page mode.
              if (!horiz) begin
                if (byte_nxt[7:4] == 4'h0)       col_q[3:0] <= byte_nxt[3:0];
                if (byte_nxt[7:3] == 5'b00010)   col_q[6:4] <= byte_nxt[2:0];
                if (byte_nxt[7:3] == 5'b10110)   page_q     <= byte_nxt[2:0];
              end
            end
            ARG1: begin
              // 01 behaves as horizontal, 11 leaves the mode alone.
              if (arg_is_mode) begin
                case (byte_nxt[1:0])
                  2'b00, 2'b01: mode_q <= MODE_H;
                  2'b10:        mode_q <= MODE_P;
                  default:      mode_q <= mode_q;
                endcase
              end
            end
            COL_S: begin
              col_start_q <= byte_nxt[6:0];
              col_q       <= byte_nxt[6:0];
            end
            COL_E:  col_end_q <= byte_nxt[6:0];
            PAGE_S: begin
              page_start_q <= byte_nxt[2:0];
              page_q       <= byte_nxt[2:0];
            end
            PAGE_E: page_end_q <= byte_nxt[2:0];
            default: ;
          endcase
        end
      end
    end
  end

  assign o_wr_en      = wr_q.en;
  assign o_wr_col     = wr_q.col;
  assign o_wr_page    = wr_q.page;
  assign o_wr_data    = wr_q.data;
  assign o_frame_done = wr_q.frame;

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// tb_ssd1306_spi_sink: scoreboard bench; a driver feeds SPI bytes and pushes
// the expected decode, a monitor pops and compares on every o_byte_valid.
module tb_ssd1306_spi_sink;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_spi_rst = 1'b1;
  logic       i_spi_cs = 1'b1;
  logic       i_spi_dc = 1'b0;
  logic       i_spi_clk = 1'b0;
  logic       i_spi_data = 1'b0;
  logic [7:0] o_byte;
  logic       o_byte_dc, o_byte_valid, o_disp_on, o_wr_en, o_frame_done;
  logic [6:0] o_wr_col;
  logic [2:0] o_wr_page;
  logic [7:0] o_wr_data;

  ssd1306_spi_sink #(.SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_spi_rst(i_spi_rst), .i_spi_cs(i_spi_cs),
    .i_spi_dc(i_spi_dc), .i_spi_clk(i_spi_clk), .i_spi_data(i_spi_data),
    .o_byte(o_byte), .o_byte_dc(o_byte_dc), .o_byte_valid(o_byte_valid),
    .o_disp_on(o_disp_on), .o_wr_en(o_wr_en), .o_wr_col(o_wr_col),
    .o_wr_page(o_wr_page), .o_wr_data(o_wr_data), .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] b;
    logic       dc;
    logic       disp;
    logic       wr;
    int         col;
    int         page;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   wr_log[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  exp_t mon_e;

  // Reference model state (panel registers as plain integers).
  logic m_disp;
  logic m_horiz;
  int   m_cs, m_ce, m_ps, m_pe, m_col, m_page;
  int   m_pend;   // 0 none, 1 mode arg, 2 skipped arg, 3/4 col window, 5/6 page window

  logic [7:0] cmd_tbl [13] = '{8'hAE, 8'hAF, 8'h20, 8'h21, 8'h22, 8'h81, 8'h8D,
                               8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int enc(input int col, input int page, input int fd);
    return (fd << 10) | (page << 7) | col;
  endfunction

  task automatic model_reset();
    m_disp = 0; m_horiz = 0; m_pend = 0;
    m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7; m_col = 0; m_page = 0;
  endtask

  // Expected effect of one complete byte.
  task automatic model_byte(input logic dc, input logic [7:0] b);
    exp_t e;
    int   p;
    e.b = b; e.dc = dc; e.wr = 0; e.col = 0; e.page = 0; e.fd = 0;
    if (dc) begin
      m_pend = 0;
      e.wr = 1; e.col = m_col; e.page = m_page;
      if (m_horiz && m_col == m_ce) begin
        m_col = m_cs;
        if (m_page == m_pe) begin m_page = m_ps; e.fd = 1; end
        else m_page = (m_page + 1) % 8;
      end else begin
        m_col = (m_col + 1) % 128;
      end
    end else if (m_pend != 0) begin
      p = m_pend;
      m_pend = 0;
      case (p)
        1: if (b[1:0] != 2'b11) m_horiz = (b[1:0] != 2'b10);
        3: begin m_cs = int'(b[6:0]); m_col = m_cs; m_pend = 4; end
        4: m_ce = int'(b[6:0]);
        5: begin m_ps = int'(b[2:0]); m_page = m_ps; m_pend = 6; end
        6: m_pe = int'(b[2:0]);
        default: ;
      endcase
    end else begin
      if (b == 8'hAE) m_disp = 0;
      else if (b == 8'hAF) m_disp = 1;
      else if (b == 8'h20) m_pend = 1;
      else if (b == 8'h21) m_pend = 3;
      else if (b == 8'h22) m_pend = 5;
      else if (b inside {8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB}) m_pend = 2;
      else if (!m_horiz) begin
        if (b <= 8'h0F) m_col = (m_col / 16) * 16 + int'(b[3:0]);
        else if (b >= 8'h10 && b <= 8'h17) m_col = (m_col % 16) + 16 * int'(b[2:0]);
        else if (b >= 8'hB0 && b <= 8'hB7) m_page = int'(b[2:0]);
      end
    end
    e.disp = m_disp;
    exp_q.push_back(e);
  endtask

  // Shift nbits of b MSB first with a random SCLK half period (>= 2 clocks).
  task automatic spi_bits(input logic dc, input logic [7:0] b, input int nbits);
    int h;
    h = $urandom_range(2, 5);
    @(negedge i_clk);
    i_spi_cs = 1'b0;
    i_spi_dc = dc;
    for (int i = 7; i >= 8 - nbits; i--) begin
      i_spi_data = b[i];
      repeat (h) @(negedge i_clk);
      i_spi_clk = 1'b1;
      if (i == 0) rise_cyc = cyc;
      repeat (h) @(negedge i_clk);
      i_spi_clk = 1'b0;
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic cs_release();
    @(negedge i_clk);
    i_spi_cs = 1'b1;
    repeat (4) @(negedge i_clk);
  endtask

  task automatic send(input logic dc, input logic [7:0] b);
    model_byte(dc, b);
    spi_bits(dc, b, 8);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge i_clk);
  endtask

  task automatic panel_reset_check();
    @(negedge i_clk);
    i_spi_rst = 1'b0;
    @(negedge i_clk);
    chk("prst_byte", {o_byte_dc, o_byte}, 0);
    chk("prst_disp", o_disp_on, 0);
    chk("prst_wr", {o_wr_en, o_wr_col, o_wr_page, o_wr_data, o_frame_done}, 0);
    @(negedge i_clk);
    i_spi_rst = 1'b1;
    model_reset();
    repeat (2) @(negedge i_clk);
  endtask

  // Monitor: every byte pulse pops one expectation.
  always @(negedge i_clk) begin
    if (o_wr_en) wr_log.push_back(enc(o_wr_col, o_wr_page, o_frame_done));
    if (o_byte_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", o_byte, 9'h100);
      end else begin
        mon_e = exp_q.pop_front();
        chk("latency", cyc - rise_cyc, 3);
        chk("byte", o_byte, mon_e.b);
        chk("byte_dc", o_byte_dc, mon_e.dc);
        chk("disp_on", o_disp_on, mon_e.disp);
        chk("wr_en", o_wr_en, mon_e.wr);
        chk("frame_done", o_frame_done, mon_e.fd);
        if (mon_e.wr) begin
          chk("wr_col", o_wr_col, mon_e.col);
          chk("wr_page", o_wr_page, mon_e.page);
          chk("wr_data", o_wr_data, mon_e.b);
        end
      end
    end else if (o_wr_en || o_frame_done) begin
      chk("stray_write", 1, 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       dc;
    int         win_exp[5];
    int         pg_exp[3];
    model_reset();
    repeat (4) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_byte", {o_byte_dc, o_byte, o_byte_valid}, 0);
    chk("rst_disp", o_disp_on, 0);
    chk("rst_wr", {o_wr_en, o_wr_col, o_wr_page, o_wr_data, o_frame_done}, 0);

    // Basic byte capture
    send(0, 8'hA5);
    cs_release();
    wait_drain();
    chk("basic_byte", o_byte, 8'hA5);

    // Display on and horizontal window 16..17 x 2..3
    send(0, 8'hAF); send(0, 8'h20); send(0, 8'h00);
    send(0, 8'h21); send(0, 8'h10); send(0, 8'h11);
    send(0, 8'h22); send(0, 8'h02); send(0, 8'h03);
    wait_drain();
    chk("win_disp", o_disp_on, 1);
    wr_log.delete();
    for (int i = 1; i <= 5; i++) send(1, 8'(i));
    wait_drain();
    win_exp = '{enc(16, 2, 0), enc(17, 2, 0), enc(16, 3, 0), enc(17, 3, 1), enc(16, 2, 0)};
    chk("win_count", wr_log.size(), 5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) chk("win_write", wr_log[i], win_exp[i]);

    // Page-mode addressing after panel reset
    panel_reset_check();
    send(0, 8'hB5); send(0, 8'h0E); send(0, 8'h17);
    wr_log.delete();
    repeat (3) send(1, 8'($urandom_range(0, 255)));
    wait_drain();
    pg_exp = '{enc(126, 5, 0), enc(127, 5, 0), enc(0, 5, 0)};
    chk("page_count", wr_log.size(), 3);
    for (int i = 0; i < 3 && i < wr_log.size(); i++) chk("page_write", wr_log[i], pg_exp[i]);

    // Aborted byte then a full 0x3C
    spi_bits(0, 8'hFF, 5);
    cs_release();
    send(0, 8'h3C);
    cs_release();
    wait_drain();
    chk("abort_byte", o_byte, 8'h3C);

    // Skipped argument swallows 0xAF; the next 0xAF is a command again
    send(0, 8'h81); send(0, 8'hAF);
    wait_drain();
    chk("skip_disp", o_disp_on, 0);
    send(0, 8'hAF);
    wait_drain();
    chk("skip_cmd", o_disp_on, 1);

    // Panel reset during a horizontal burst
    send(0, 8'h20); send(0, 8'h00);
    send(0, 8'h21); send(0, 8'h05); send(0, 8'h30);
    repeat (3) send(1, 8'($urandom_range(0, 255)));
    wait_drain();
    panel_reset_check();
    wr_log.delete();
    send(1, 8'h55);
    wait_drain();
    chk("rst_wr_count", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("rst_wr_addr", wr_log[0], enc(0, 0, 0));

    // Random mixed stream
    for (int n = 0; n < 300; n++) begin
      dc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       b = cmd_tbl[$urandom_range(0, 12)];
        1:       b = 8'($urandom_range(0, 15));
        2:       b = 8'h10 | 8'($urandom_range(0, 7));
        3:       b = 8'hB0 | 8'($urandom_range(0, 7));
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 19) == 0) begin
        spi_bits(dc, b, $urandom_range(1, 7));
        cs_release();
      end
      send(dc, b);
      if ($urandom_range(0, 3) == 0) cs_release();
      if ($urandom_range(0, 49) == 0) begin
        wait_drain();
        panel_reset_check();
      end
    end
    cs_release();
    wait_drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
